serial_signed_addsub_ctrl: RTL and testbench

Controller that runs a bit-serial signed add/subtract over a single 1-bit adder slice, one bit per clock, LSB first. The slice is two half adders plus an OR for carry. It sits in the Signed_calc datapath between the operand/switch registers and the result display logic. It uses a start/busy/done handshake and reports two's-complement overflow and zero.

---
 rtl/serial_signed_addsub_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_signed_addsub_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_signed_addsub_ctrl.sv
// Bit-serial signed add/subtract over one 1-bit adder slice, LSB first, start/busy/done handshake.
// Latency: start edge + WIDTH RUN edges, done pulses the cycle after; start ignored while busy.
module serial_signed_addsub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    // Adder slice: two half adders, carries merged by an OR.
    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             carry_out;
    logic             last_bit;
    logic [WIDTH-1:0] res_shifted;

    assign ha1_s       = sa[0] ^ sb[0];
    assign ha1_c       = sa[0] & sb[0];
    assign ha2_s       = ha1_s ^ carry;
    assign ha2_c       = ha1_s & carry;
    assign carry_out   = ha1_c | ha2_c;
    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign res_shifted = {ha2_s, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: invert b at capture and seed the carry with op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= op ? ~b : b;
                        carry <= op;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    carry  <= carry_out;
                    res_sr <= res_shifted;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        overflow <= carry ^ carry_out;
                        zero     <= (res_shifted == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = res_sr;

endmodule

// File: tb/tb_serial_signed_addsub_ctrl.sv
// Directed-vector bench for serial_signed_addsub_ctrl (WIDTH=8).
module tb_serial_signed_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_signed_addsub_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .zero     (zero)
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vop;
        logic [7:0] er;
        logic       eo;
        logic       ez;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation, scramble inputs after capture, check latency and results.
    task automatic run_op(input vec_t v, input string tag);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        a     = v.va;
        b     = v.vb;
        op    = v.vop;
        start = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                start = 1'b0;
                a     = ~v.va;
                b     = v.vb + 8'd37;
                op    = ~v.vop;
            end
            lat++;
            @(negedge clk);
            if (done) seen = 1;
        end
        check({tag, "_timeout"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(lat), 32'd9);
            check({tag, "_result"}, 32'(result), 32'(v.er));
            check({tag, "_overflow"}, 32'(overflow), 32'(v.eo));
            check({tag, "_zero"}, 32'(zero), 32'(v.ez));
            check({tag, "_busy_done"}, 32'(busy), 32'd1);
            @(negedge clk);
            check({tag, "_after"}, {20'd0, done, busy, overflow, zero, result},
                  {20'd0, 1'b0, 1'b0, v.eo, v.ez, v.er});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd5,    8'd3,  1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'd100,  8'd50, 1'b0, 8'h96, 1'b1, 1'b0};
        vecs[2] = '{8'h9C,   8'hCE, 1'b0, 8'h6A, 1'b1, 1'b0};
        vecs[3] = '{8'd5,    8'd5,  1'b1, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h80,   8'd1,  1'b1, 8'h7F, 1'b1, 1'b0};
        vecs[5] = '{8'd3,    8'd7,  1'b1, 8'hFC, 1'b0, 1'b0};
        vecs[6] = '{8'h7F,   8'h01, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[7] = '{8'h00,   8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[8] = '{8'hFF,   8'h01, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{8'd20,   8'd10, 1'b0, 8'h1E, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_outputs", {busy, done, overflow, zero, result}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_hold", {busy, done, overflow, zero, result}, 12'h000);
        end

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high: one operation every 10 cycles, done one cycle wide
        @(negedge clk);
        a     = 8'd1;
        b     = 8'd1;
        op    = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("held_done_c%0d", k), 32'(done), 32'((k % 10) == 9));
            if ((k % 10) == 9) begin
                check($sformatf("held_result_c%0d", k), 32'(result), 32'h02);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("held_idle", {busy, done, overflow, zero, result}, {4'b0000, 8'h02});

        // abort mid-RUN by reset
        @(negedge clk);
        a     = 8'd20;
        b     = 8'd10;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_clear", {busy, done, overflow, zero, result}, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("post_reset_quiet", {busy, done}, 2'b00);
        end
        run_op(vecs[9], "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
